// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman front end (frequency counter and encoder).
// Odd-even transposition sorting is compiled in when HUFF_FREQ_SORT_EN is defined.
package huff_pkg;

   localparam int unsigned NUM_SYM = 3;
   localparam int unsigned CHAR_W  = 8;
   localparam int unsigned FREQ_W  = 3;
   localparam int unsigned WORD_W  = 1 + FREQ_W + CHAR_W;
   localparam int unsigned SLOT_W  = 1 + FREQ_W + CHAR_W;
   localparam int unsigned IDX_W   = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
   localparam int unsigned CNT_W   = $clog2(NUM_SYM + 1);

   localparam logic [FREQ_W-1:0] FREQ_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_SYM - 1);
   localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(NUM_SYM);

   typedef struct packed {
      logic              used;
      logic [FREQ_W-1:0] freq;
      logic [CHAR_W-1:0] chr;
   } slot_t;

   // Layout shared with the encoder's input port.
   typedef struct packed {
      logic              valid;
      logic [FREQ_W-1:0] freq;
      logic [CHAR_W-1:0] chr;
   } word_t;

   typedef enum logic [1:0] {
      StCount,
      StSort,
      StEmit
   } state_e;

endpackage

// File: rtl/huff_cmp_swap.sv
// Compare-and-conditional-swap of two slots; the higher frequency moves to the lower index.
// A strict comparison keeps equal-frequency slots in their original order.
module huff_cmp_swap
   import huff_pkg::*;
(
   input  logic [SLOT_W-1:0] a_i,
   input  logic [SLOT_W-1:0] b_i,
   output logic [SLOT_W-1:0] a_o,
   output logic [SLOT_W-1:0] b_o
);

   slot_t a;
   slot_t b;

   always_comb begin
      a = slot_t'(a_i);
      b = slot_t'(b_i);
      if (a.freq < b.freq) begin
         a_o = b_i;
         b_o = a_i;
      end else begin
         a_o = a_i;
         b_o = b_i;
      end
   end

endmodule

// File: rtl/huff_freq_counter.sv
// Counts distinct characters of a message, optionally sorts by frequency, then emits one
// encoder word per slot. Define HUFF_FREQ_SORT_EN to include the SORT state and network.
module huff_freq_counter
   import huff_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CHAR_W-1:0] in_char,
   input  logic              in_last,
   output logic [WORD_W-1:0] out_word,
   output logic              out_done,
   output logic              overflow
);

   state_e             state_q, state_d;
   slot_t              slots_q [NUM_SYM];
   slot_t              slots_d [NUM_SYM];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   word_t              word_q, word_d;
   logic               done_q, done_d;

   logic               hit, free_found;
   logic [IDX_W-1:0]   hit_idx, free_idx;

`ifdef HUFF_FREQ_SORT_EN
   slot_t sw_a [NUM_SYM-1];
   slot_t sw_b [NUM_SYM-1];

   for (genvar k = 0; k < NUM_SYM - 1; k++) begin : g_pair
      huff_cmp_swap u_cmp_swap (
         .a_i (slots_q[k]),
         .b_i (slots_q[k+1]),
         .a_o (sw_a[k]),
         .b_o (sw_b[k])
      );
   end
`endif

   assign in_ready = (state_q == StCount);
   assign out_word = word_q;
   assign out_done = done_q;
   assign overflow = ovf_q;

   // Parallel match against used slots and lowest-index free slot search.
   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned k = 0; k < NUM_SYM; k++) begin
         if (!hit && slots_q[k].used && (slots_q[k].chr == in_char)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(k);
         end
         if (!free_found && !slots_q[k].used) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(k);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      slots_d = slots_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      word_d  = '0;
      done_d  = 1'b0;
      unique case (state_q)
         StCount: begin
            if (in_valid) begin
               if (hit) begin
                  if (slots_q[hit_idx].freq != FREQ_MAX) begin
                     slots_d[hit_idx].freq = slots_q[hit_idx].freq + 1'b1;
                  end
               end else if (free_found) begin
                  slots_d[free_idx] = '{used: 1'b1, freq: FREQ_W'(1), chr: in_char};
               end else begin
                  ovf_d = 1'b1;
               end
               if (in_last) begin
                  cnt_d = '0;
`ifdef HUFF_FREQ_SORT_EN
                  state_d = StSort;
`else
                  state_d = StEmit;
`endif
               end
            end
         end
`ifdef HUFF_FREQ_SORT_EN
         StSort: begin
            // Even phases compare pairs (0,1),(2,3)..; odd phases (1,2),(3,4)..
            for (int unsigned k = 0; k < NUM_SYM - 1; k++) begin
               if (cnt_q[0] == 1'(k % 2)) begin
                  slots_d[k]   = sw_a[k];
                  slots_d[k+1] = sw_b[k];
               end
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = StEmit;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         StEmit: begin
            if (cnt_q == CNT_END) begin
               done_d  = 1'b1;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = StCount;
               for (int unsigned k = 0; k < NUM_SYM; k++) begin
                  slots_d[k] = '0;
               end
            end else begin
               word_d = '{valid: 1'b1, freq: slots_q[cnt_q].freq, chr: slots_q[cnt_q].chr};
               cnt_d  = cnt_q + 1'b1;
            end
         end
         default: state_d = StCount;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StCount;
         for (int unsigned k = 0; k < NUM_SYM; k++) begin
            slots_q[k] <= '0;
         end
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         word_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         slots_q <= slots_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         word_q  <= word_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: doc/huff_freq_counter.md
Name: huff_freq_counter

Overview:
- Upstream stage of huff_encoder. Consumes a raw character stream and counts occurrences of up to NUM_SYM distinct characters.
- Optionally orders the entries by descending frequency.
- Emits one 12-bit word per symbol in the encoder's input format {valid, freq[2:0], char[7:0]} on consecutive cycles; out_word connects directly to huff_encoder io_in.

Parameters:
- NUM_SYM, 3, number of distinct symbol slots and number of words emitted per message.
- CHAR_W, 8, character width.
- FREQ_W, 3, frequency counter width; saturates at 2^FREQ_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_char is valid this cycle.
- in_ready  output  1  block accepts a character; a transfer occurs when in_valid && in_ready.
- in_char  input  CHAR_W  character.
- in_last  input  1  qualifies the final character of a message; sampled only on a transfer.
- out_word  output  1+FREQ_W+CHAR_W  {valid, freq, char}; registered.
- out_done  output  1  one-cycle pulse on the cycle after the last word of a message is emitted.
- overflow  output  1  sticky per message: more than NUM_SYM distinct characters were seen.

Behaviour:
- Reset (async, reset low):
  - state=COUNT, all slots cleared (used=0, freq=0, char=0).
  - in_ready=1, out_word=0, out_done=0, overflow=0.
- States: COUNT -> SORT -> EMIT -> COUNT.
- COUNT:
  - in_ready=1, out_word valid bit=0.
  - On a transfer, compare in_char with all used slots in parallel.
  - Hit: that slot's freq += 1, saturating at 7.
  - Miss with a free slot: allocate the lowest-index free slot with freq=1.
  - Miss with no free slot: drop the character and set overflow=1.
  - A transfer with in_last=1 is counted in that same cycle, then the block moves to SORT (or straight to EMIT when the sort feature is compiled out).
- SORT:
  - in_ready=0.
  - Odd-even transposition sort over the slots, one phase per cycle, exactly NUM_SYM cycles.
  - Adjacent slots swap only if freq[k] < freq[k+1] (strict), so ties keep first-appearance order.
  - Unused slots have freq=0 and therefore sink to the end.
- EMIT:
  - in_ready=0.
  - For NUM_SYM consecutive cycles, out_word = {1, freq[k], char[k]} for k=0..NUM_SYM-1.
  - Unused slots are emitted as {1, 0, 0}, so the encoder always receives exactly NUM_SYM words.
  - The cycle after the last word: out_word=0, out_done=1, all slots cleared, overflow cleared, state=COUNT, in_ready=1.
- Latency: in_last accepted at cycle N; first word valid at N+NUM_SYM+1 with sort, N+1 without.
- Boundary cases:
  - A single-character message (in_last on the first transfer) is legal.
  - in_valid while in_ready=0 is ignored; no transfer occurs.
  - in_last without in_valid has no effect.
  - Counter saturation does not set overflow.
  - Reset asserted mid-SORT or mid-EMIT aborts the message immediately to reset values; no partial out_done.

Optional Feature:
- Macro HUFF_FREQ_SORT_EN.
- Defined: SORT state present; output order is descending frequency, stable on ties.
- Undefined: SORT state and sort network removed; COUNT goes directly to EMIT; output order is first-appearance order.

Decomposition:
- Shared package huff_pkg:
  - NUM_SYM, CHAR_W, FREQ_W constants.
  - Slot struct {used, freq, char}.
  - Output word layout typedef {valid, freq, char}, which huff_encoder also uses.
  - State enum {COUNT, SORT, EMIT}.
- One natural sub-module: huff_cmp_swap, a combinational compare-and-conditional-swap of two slots, instantiated per adjacent pair in the sort network.

Test Plan (values assume defaults, HUFF_FREQ_SORT_EN defined unless noted):
- "ABA" (0x41,0x42,0x41, last on third) -> words 0xA41, 0x942, 0x800, then out_done pulse; overflow=0.
- "BCCC" -> 0xB43, 0x942, 0x800; first word exactly 4 cycles after the last accepted character.
- Nine 'A' -> 0xF41, 0x800, 0x800 (saturates at 7, overflow=0).
- "ABCD" -> 0x941, 0x942, 0x943; overflow=1 during EMIT, cleared after out_done.
- "BA" tie -> 0x942, 0x941, 0x800 (stable); with the macro undefined, the same order appears one cycle after last.
- Reset pulled low on the second EMIT word of "ABA" -> out_word=0 immediately, in_ready=1; a following "C" message yields 0x943, 0x800, 0x800.
